// File: rtl/pe_pkg.sv
// pe_pkg: shared packet layout, widths and FSM states for the PE controller
// Exports: pkt_t (ptype/dest/src/data), PKT_W, DATA_W, NODE_W,
//          TYPE_FILTER, TYPE_IFMAP, TYPE_PSUM, state_t
package pe_pkg;
  localparam int PKT_W = 33;
  localparam int DATA_W = 24;
  localparam int NODE_W = 4;
  localparam logic TYPE_FILTER = 1'b0;
  localparam logic TYPE_IFMAP = 1'b1;
  localparam logic TYPE_PSUM = 1'b1;
  typedef struct packed {
    logic ptype;
    logic [NODE_W-1:0] dest;
    logic [NODE_W-1:0] src;
    logic [DATA_W-1:0] data;
  } pkt_t;
  typedef enum logic [1:0] {ST_LOAD, ST_COMPUTE, ST_DRAIN, ST_SEND} state_t;
endpackage

// File: rtl/pe_cnt.sv
// pe_cnt: saturating up-counter with synchronous clear
// Ports: clk, rst_n (sync active-low), clr (priority over inc), inc,
//        cnt (current value), full (cnt == MAX, further inc ignored)
module pe_cnt #(
  parameter int W = 3,
  parameter int MAX = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         full
);
  logic [W-1:0] cnt_q, cnt_d;
  assign full = cnt_q == W'(MAX);
  assign cnt_d = clr ? '0 : (inc && !full) ? cnt_q + W'(1) : cnt_q;
  assign cnt = cnt_q;
  always_ff @(posedge clk) begin
    cnt_q <= !rst_n ? '0 : cnt_d;
  end
endmodule

// File: rtl/pe_ctrl.sv
// pe_ctrl: processing-element controller loading filter/ifmap words, sequencing the MAC and emitting psum packets
// Ports: clk, rst_n (sync active-low)
//        in_valid/in_ready/in_pkt   : packet input (type 0 filter, type 1 ifmap)
//        filt_we/addr/wdata         : filter memory write port
//        ifmap_we/addr/wdata        : ifmap memory write port
//        mac_en/mac_clr/mac_addr    : MAC sequencing, psum_in is the MAC result
//        out_valid/out_ready/out_pkt: psum packet output
//        busy                       : high whenever not in LOAD
module pe_ctrl
  import pe_pkg::*;
#(
  parameter int FILT_LEN = 5,
  parameter int NUM_OUT = 3,
  parameter logic [NODE_W-1:0] SRC_ID = 4'b0011,
  parameter logic [NODE_W-1:0] DEST_ID = 4'b1101
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PKT_W-1:0]  in_pkt,
  output logic              filt_we,
  output logic [2:0]        filt_addr,
  output logic [DATA_W-1:0] filt_wdata,
  output logic              ifmap_we,
  output logic [2:0]        ifmap_addr,
  output logic [DATA_W-1:0] ifmap_wdata,
  output logic              mac_en,
  output logic              mac_clr,
  output logic [2:0]        mac_addr,
  input  logic [DATA_W-1:0] psum_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PKT_W-1:0]  out_pkt,
  output logic              busy
);
  localparam int OUT_W = $clog2(NUM_OUT + 1);
  state_t state_q, state_d;
  pkt_t pkt;
  logic [2:0] filt_cnt, ifmap_cnt, tap_cnt;
  logic filt_full, ifmap_full, tap_last;
  logic [OUT_W-1:0] out_cnt_q, out_cnt_d;
  logic [DATA_W-1:0] psum_q, psum_d;
  logic in_load, in_comp, in_drain, in_send, fire_in, fire_out, retire;
  logic unused_hdr;
  assign pkt = pkt_t'(in_pkt);
  assign unused_hdr = ^{pkt.dest, pkt.src};
  // state decodes are gated by rst_n so every strobe is low while reset is held
  assign in_load = rst_n && state_q == ST_LOAD;
  assign in_comp = rst_n && state_q == ST_COMPUTE;
  assign in_drain = rst_n && state_q == ST_DRAIN;
  assign in_send = rst_n && state_q == ST_SEND;
  // ready follows the presented packet type, so a full memory stalls only its own type
  assign in_ready = in_load && (pkt.ptype == TYPE_FILTER ? !filt_full : !ifmap_full);
  assign fire_in = in_valid && in_ready;
  assign filt_we = fire_in && pkt.ptype == TYPE_FILTER;
  assign ifmap_we = fire_in && pkt.ptype == TYPE_IFMAP;
  assign filt_addr = filt_cnt;
  assign ifmap_addr = ifmap_cnt;
  assign filt_wdata = pkt.data;
  assign ifmap_wdata = pkt.data;
  assign mac_en = in_comp;
  assign mac_clr = in_comp && tap_cnt == 3'd0;
  assign mac_addr = tap_cnt;
  assign out_valid = in_send;
  assign out_pkt = in_send ? {TYPE_PSUM, DEST_ID, SRC_ID, psum_q} : '0;
  assign busy = rst_n && state_q != ST_LOAD;
  assign fire_out = in_send && out_ready;
  // the last output for this filter frees the filter memory for a new load
  assign retire = fire_out && out_cnt_q == OUT_W'(NUM_OUT - 1);
  pe_cnt #(.W(3), .MAX(FILT_LEN)) u_filt_cnt (
    .clk(clk), .rst_n(rst_n), .clr(retire), .inc(filt_we), .cnt(filt_cnt), .full(filt_full)
  );
  pe_cnt #(.W(3), .MAX(FILT_LEN)) u_ifmap_cnt (
    .clk(clk), .rst_n(rst_n), .clr(fire_out), .inc(ifmap_we), .cnt(ifmap_cnt), .full(ifmap_full)
  );
  // tap index wraps to 0 on its last COMPUTE cycle, ready for the next output
  pe_cnt #(.W(3), .MAX(FILT_LEN - 1)) u_tap_cnt (
    .clk(clk), .rst_n(rst_n), .clr(in_comp && tap_last), .inc(in_comp), .cnt(tap_cnt), .full(tap_last)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD:    state_d = (filt_full && ifmap_full) ? ST_COMPUTE : ST_LOAD;
      ST_COMPUTE: state_d = tap_last ? ST_DRAIN : ST_COMPUTE;
      ST_DRAIN:   state_d = ST_SEND;
      ST_SEND:    state_d = out_ready ? ST_LOAD : ST_SEND;
      default:    state_d = ST_LOAD;
    endcase
    out_cnt_d = retire ? '0 : fire_out ? out_cnt_q + OUT_W'(1) : out_cnt_q;
    psum_d = in_drain ? psum_in : psum_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_LOAD;
      out_cnt_q <= '0;
      psum_q <= '0;
    end else begin
      state_q <= state_d;
      out_cnt_q <= out_cnt_d;
      psum_q <= psum_d;
    end
  end
endmodule
